// File: rtl/dict_search.sv
// dict_search: key -> value dictionary with per-entry valid bits, lowest-free-slot
// allocation and occupancy status. Keyed lookups scan LANES entries per cycle;
// indexed (FAST) operations, CLEAR and the reserved op answer one cycle after accept.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_valid, o_ready  request handshake (o_ready high only in IDLE)
//   i_op              0 SET, 1 GET, 2 DELETE, 3 ENCODE, 4 GET_FAST, 5 SET_FAST,
//                     6 CLEAR, 7 reserved
//   i_key             flattened key, char 0 in [KEY_WIDTH-1:0]
//   i_index           entry index for FAST ops
//   i_value           write value
//   o_valid           one-cycle response pulse; other response outputs hold between pulses
//   o_found, o_err    entry was valid / request failed
//   o_index, o_value  resolved index, read or old value
//   o_count, o_full   number of valid entries, table full
//   o_hits, o_misses  lookup statistics (zero unless DICT_STATS_EN is defined)
//
// Build option: define DICT_STATS_EN to include saturating hit/miss counters.
module dict_search #(
  parameter int ENTRIES     = 16,
  parameter int KEY_WIDTH   = 8,
  parameter int KEY_LENGTH  = 8,
  parameter int VALUE_WIDTH = 32,
  parameter int LANES       = 4,
  localparam int IB = $clog2(ENTRIES),
  localparam int CB = $clog2(ENTRIES + 1),
  localparam int KW = KEY_WIDTH * KEY_LENGTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [2:0]             i_op,
  input  logic [KW-1:0]          i_key,
  input  logic [IB-1:0]          i_index,
  input  logic [VALUE_WIDTH-1:0] i_value,
  output logic                   o_valid,
  output logic                   o_found,
  output logic                   o_err,
  output logic [IB-1:0]          o_index,
  output logic [VALUE_WIDTH-1:0] o_value,
  output logic [CB-1:0]          o_count,
  output logic                   o_full,
  output logic [15:0]            o_hits,
  output logic [15:0]            o_misses
);

  localparam logic [2:0] OP_SET      = 3'd0;
  localparam logic [2:0] OP_GET      = 3'd1;
  localparam logic [2:0] OP_DELETE   = 3'd2;
  localparam logic [2:0] OP_GET_FAST = 3'd4;
  localparam logic [2:0] OP_SET_FAST = 3'd5;
  localparam logic [2:0] OP_CLEAR    = 3'd6;

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t                 state;
  logic [ENTRIES-1:0]     vld_bits;
  logic [KW-1:0]          keys [ENTRIES];
  logic [VALUE_WIDTH-1:0] vals [ENTRIES];
  logic [CB-1:0]          count;
  logic [IB-1:0]          base;       // first entry of the group under comparison
  logic                   free_seen;  // a free slot was found in an earlier group
  logic [IB-1:0]          free_idx;

  // Latched request; shared by the keyed search and the one-cycle FAST stage,
  // which never overlap because FAST ops are only accepted in IDLE.
  logic [2:0]             req_op;
  logic [KW-1:0]          req_key;
  logic [IB-1:0]          req_idx;
  logic [VALUE_WIDTH-1:0] req_val;
  logic                   fast_vld_p1;

  logic          accept, is_search_op, hit_any, gfree_any, last_grp, free_any;
  logic          stop, fast_ok, fast_hit;
  logic [IB-1:0] hit_idx, gfree_idx, free_sel, lane_idx;

  assign o_ready      = (state == IDLE);
  assign accept       = i_valid & o_ready;
  assign is_search_op = (i_op < 3'd4);
  assign o_count      = count;
  assign o_full       = (count == CB'(ENTRIES));

  // Compare the current group; walking lanes downward leaves the lowest
  // matching index and the lowest free index in the result.
  always_comb begin
    hit_any   = 1'b0;
    hit_idx   = '0;
    gfree_any = 1'b0;
    gfree_idx = '0;
    lane_idx  = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      lane_idx = base + IB'(l);
      if (vld_bits[lane_idx] && (keys[lane_idx] == req_key)) begin
        hit_any = 1'b1;
        hit_idx = lane_idx;
      end
      if (!vld_bits[lane_idx]) begin
        gfree_any = 1'b1;
        gfree_idx = lane_idx;
      end
    end
  end

  assign last_grp = (base == IB'(ENTRIES - LANES));
  assign free_any = free_seen | gfree_any;
  assign free_sel = free_seen ? free_idx : gfree_idx;
  assign stop     = (state == SEARCH) && (hit_any || last_grp);
  assign fast_ok  = ({1'b0, req_idx} < (IB + 1)'(ENTRIES));
  assign fast_hit = fast_ok && vld_bits[req_idx];

  // Request capture (p0 -> p1 boundary)
  always_ff @(posedge i_clk) begin
    if (accept) begin
      req_op  <= i_op;
      req_key <= i_key;
      req_idx <= i_index;
      req_val <= i_value;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      vld_bits    <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        keys[i] <= '0;
        vals[i] <= '0;
      end
      count       <= '0;
      base        <= '0;
      free_seen   <= 1'b0;
      free_idx    <= '0;
      fast_vld_p1 <= 1'b0;
      o_valid     <= 1'b0;
      o_found     <= 1'b0;
      o_err       <= 1'b0;
      o_index     <= '0;
      o_value     <= '0;
    end else begin
      o_valid     <= 1'b0;
      fast_vld_p1 <= accept && !is_search_op;

      case (state)
        IDLE: begin
          if (accept && is_search_op) begin
            state     <= SEARCH;
            base      <= '0;
            free_seen <= 1'b0;
          end
        end
        SEARCH: begin
          if (stop) begin
            state <= IDLE;
          end else begin
            base <= base + IB'(LANES);
            if (!free_seen && gfree_any) begin
              free_seen <= 1'b1;
              free_idx  <= gfree_idx;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // FAST / CLEAR / reserved response (p1)
      if (fast_vld_p1) begin
        o_valid <= 1'b1;
        o_found <= 1'b0;
        o_err   <= 1'b0;
        o_index <= req_idx;
        o_value <= '0;
        case (req_op)
          OP_GET_FAST: begin
            if (!fast_ok) begin
              o_err <= 1'b1;
            end else if (fast_hit) begin
              o_found <= 1'b1;
              o_value <= vals[req_idx];
            end
          end
          OP_SET_FAST: begin
            if (fast_hit) begin
              vals[req_idx] <= req_val;
              o_found       <= 1'b1;
            end else begin
              o_err <= 1'b1;
            end
          end
          OP_CLEAR: begin
            vld_bits <= '0;
            count    <= '0;
            o_index  <= '0;
          end
          default: begin
            o_err   <= 1'b1;
            o_index <= '0;
          end
        endcase
      end

      // Keyed search response at the stop edge
      if (stop) begin
        o_valid <= 1'b1;
        o_found <= hit_any;
        o_err   <= 1'b0;
        o_index <= hit_any ? hit_idx : '0;
        o_value <= '0;
        case (req_op)
          OP_SET: begin
            if (hit_any) begin
              vals[hit_idx] <= req_val;
            end else if (free_any) begin
              keys[free_sel]     <= req_key;
              vals[free_sel]     <= req_val;
              vld_bits[free_sel] <= 1'b1;
              count              <= count + CB'(1);
              o_index            <= free_sel;
            end else begin
              o_err <= 1'b1;
            end
          end
          OP_GET: begin
            if (hit_any) o_value <= vals[hit_idx];
          end
          OP_DELETE: begin
            if (hit_any) begin
              o_value           <= vals[hit_idx];
              vld_bits[hit_idx] <= 1'b0;
              keys[hit_idx]     <= '0;
              vals[hit_idx]     <= '0;
              count             <= count - CB'(1);
            end
          end
          default: ;  // ENCODE reports index only
        endcase
      end
    end
  end

`ifdef DICT_STATS_EN
  logic        resp_hit, resp_miss, stats_clr;
  logic [15:0] hits, misses;

  assign resp_hit  = (stop && hit_any) ||
                     (fast_vld_p1 && (req_op == OP_GET_FAST) && fast_hit);
  assign resp_miss = (stop && !hit_any) ||
                     (fast_vld_p1 && (req_op == OP_GET_FAST) && !fast_hit);
  assign stats_clr = fast_vld_p1 && (req_op == OP_CLEAR);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hits   <= '0;
      misses <= '0;
    end else if (stats_clr) begin
      hits   <= '0;
      misses <= '0;
    end else begin
      if (resp_hit && (hits != 16'hFFFF))     hits   <= hits + 16'd1;
      if (resp_miss && (misses != 16'hFFFF)) misses <= misses + 16'd1;
    end
  end

  assign o_hits   = hits;
  assign o_misses = misses;
`else
  assign o_hits   = '0;
  assign o_misses = '0;
`endif

endmodule
